sram_access_ctrl: RTL and testbench

Initiator-side controller for the byte-strobed internal SRAM. It accepts byte-addressed read and write requests of 1 to 2^log2_dbytes bytes at any alignment. Each request becomes one or two word accesses with lane strobes. Write data is shifted onto the correct lanes, and read data is merged and right-justified into a single response. The block sits between a CPU or debug bus adapter and the SRAM's addr/we/wstrb/wdata/rdata port.

---
 rtl/sram_access_ctrl_pkg.sv | 18 +
 rtl/sram_lane_align.sv | 29 ++
 rtl/sram_access_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_access_ctrl_pkg.sv
// rtl/sram_access_ctrl_pkg.sv - shared state type, size constants and strobe-mask helper for sram_access_ctrl
package sram_access_ctrl_pkg;
  localparam int SIZE_W   = 3;
  localparam int MAX_SIZE = 3;
  localparam int MASK_W   = 2 * (1 << MAX_SIZE);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, LAST, RESP} state_t;

  // (1 << n) - 1 placed at byte offset off inside a two-word strobe field
  function automatic logic [MASK_W-1:0] strobe_mask(input logic [MAX_SIZE-1:0] off,
                                                    input logic [SIZE_W-1:0] size);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W / 2; i++)
      if (i < (int'(1) << size)) m[i] = 1'b1;
    return m << off;
  endfunction
endpackage

// File: rtl/sram_lane_align.sv
// rtl/sram_lane_align.sv - combinational write-lane shifter and read-data right-justify/zero-extend
module sram_lane_align
  import sram_access_ctrl_pkg::*;
#(
  parameter int log2_dbytes = MAX_SIZE,
  parameter int dbytes      = 1 << log2_dbytes,
  parameter int dbits       = 8 * dbytes
) (
  input  logic [log2_dbytes-1:0] off,
  input  logic [SIZE_W-1:0]      size,
  input  logic [dbits-1:0]       wdata,
  output logic [dbits-1:0]       wlane0,
  output logic [dbits-1:0]       wlane1,
  input  logic [dbits-1:0]       rdata0,
  input  logic [dbits-1:0]       rdata1,
  output logic [dbits-1:0]       rdata
);
  logic [2*dbits-1:0] wwide;

  assign wwide  = {{dbits{1'b0}}, wdata} << {off, 3'b000};
  assign wlane0 = wwide[dbits-1:0];
  assign wlane1 = wwide[2*dbits-1:dbits];

  always_comb begin
    rdata = dbits'({rdata1, rdata0} >> {off, 3'b000});
    for (int b = 0; b < dbytes; b++)
      if (b >= (int'(1) << size)) rdata[8*b +: 8] = 8'h00;
  end
endmodule

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - byte-addressed SRAM access controller; SRAM_ACCESS_CTRL_SPLIT_EN enables word-crossing splits
module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter int abits       = 16,
  parameter int log2_dbytes = MAX_SIZE,
  parameter int dbytes      = 1 << log2_dbytes,
  parameter int dbits       = 8 * dbytes
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [abits-1:0]  i_req_addr,
  input  logic [SIZE_W-1:0] i_req_size,
  input  logic [dbits-1:0]  i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [dbits-1:0]  o_resp_rdata,
  output logic              o_resp_err,
  output logic [abits-1:0]  o_mem_addr,
  output logic              o_mem_we,
  output logic [dbytes-1:0] o_mem_wstrb,
  output logic [dbits-1:0]  o_mem_wdata,
  input  logic [dbits-1:0]  i_mem_rdata
);
  localparam int wbits = abits - log2_dbytes;
  localparam int ew    = log2_dbytes + 2;

  state_t state, state_nx;
  logic                   write_r, cross_r, err_r;
  logic [abits-1:0]       addr_r, mem_addr_q;
  logic [SIZE_W-1:0]      size_r;
  logic [dbits-1:0]       wdata_r, rdata0_r, rdata_r, mem_wdata_q;

  logic [ew-1:0]          req_end;
  logic                   accept, req_cross, req_bad, req_err;
  logic [log2_dbytes-1:0] off_r;
  logic [wbits-1:0]       w0, w1;
  logic [MASK_W-1:0]      mask_full;
  logic [dbytes-1:0]      strb0, strb1;
  logic [dbits-1:0]       wlane0, wlane1, merge_rd0, merge_rd1, merged;

  assign accept    = (state == IDLE) && i_req_valid;
  assign req_end   = ew'(i_req_addr[log2_dbytes-1:0]) + (ew'(1) << i_req_size);
  assign req_cross = req_end > ew'(dbytes);
  assign req_bad   = i_req_size > SIZE_W'(log2_dbytes);
`ifdef SRAM_ACCESS_CTRL_SPLIT_EN
  assign req_err   = req_bad;
`else
  assign req_err   = req_bad || req_cross;
`endif

  assign off_r     = addr_r[log2_dbytes-1:0];
  assign w0        = addr_r[abits-1:log2_dbytes];
  assign w1        = w0 + wbits'(1);
  assign mask_full = strobe_mask(MAX_SIZE'(off_r), size_r);
  assign strb0     = mask_full[dbytes-1:0];
  assign strb1     = mask_full[2*dbytes-1:dbytes];

  // word 0 of a crossing read was parked in rdata0_r during ACC1
  assign merge_rd0 = cross_r ? rdata0_r : i_mem_rdata;
  assign merge_rd1 = cross_r ? i_mem_rdata : '0;

  sram_lane_align #(
    .log2_dbytes(log2_dbytes),
    .dbytes     (dbytes),
    .dbits      (dbits)
  ) u_align (
    .off   (off_r),
    .size  (size_r),
    .wdata (wdata_r),
    .wlane0(wlane0),
    .wlane1(wlane1),
    .rdata0(merge_rd0),
    .rdata1(merge_rd1),
    .rdata (merged)
  );

`ifndef SRAM_ACCESS_CTRL_SPLIT_EN
  logic unused_split;
  assign unused_split = ^{w1, strb1, wlane1};
`endif

  always_comb begin
    state_nx     = state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_nx = req_err ? RESP : ACC0;
      end
      ACC0: begin
        state_nx = write_r ? RESP : LAST;
`ifdef SRAM_ACCESS_CTRL_SPLIT_EN
        if (cross_r) state_nx = ACC1;
`endif
      end
`ifdef SRAM_ACCESS_CTRL_SPLIT_EN
      ACC1: state_nx = write_r ? RESP : LAST;
`endif
      LAST: state_nx = RESP;
      RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // combinational from state so a reset drops o_mem_we without waiting for a clock
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_wstrb = '0;
    o_mem_addr  = mem_addr_q;
    o_mem_wdata = mem_wdata_q;
    if (state == ACC0) begin
      o_mem_we    = write_r;
      o_mem_wstrb = strb0;
      o_mem_addr  = {w0, {log2_dbytes{1'b0}}};
      o_mem_wdata = wlane0;
    end
`ifdef SRAM_ACCESS_CTRL_SPLIT_EN
    if (state == ACC1) begin
      o_mem_we    = write_r;
      o_mem_wstrb = strb1;
      o_mem_addr  = {w1, {log2_dbytes{1'b0}}};
      o_mem_wdata = wlane1;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      write_r     <= 1'b0;
      cross_r     <= 1'b0;
      err_r       <= 1'b0;
      addr_r      <= '0;
      size_r      <= '0;
      wdata_r     <= '0;
      rdata0_r    <= '0;
      rdata_r     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        write_r <= i_req_write;
        addr_r  <= i_req_addr;
        size_r  <= i_req_size;
        wdata_r <= i_req_wdata;
        cross_r <= req_cross;
        err_r   <= req_err;
        rdata_r <= '0;
      end
      if (state == ACC0 || state == ACC1) begin
        mem_addr_q  <= o_mem_addr;
        mem_wdata_q <= o_mem_wdata;
      end
      if (state == ACC1) rdata0_r <= i_mem_rdata;
      if (state == LAST) rdata_r <= merged;
    end
  end

  assign o_resp_rdata = rdata_r;
  assign o_resp_err   = err_r;
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - scoreboard bench for sram_access_ctrl; follows SRAM_ACCESS_CTRL_SPLIT_EN
module tb_sram_access_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid, o_req_ready, i_req_write;
  logic [15:0] i_req_addr;
  logic [2:0]  i_req_size;
  logic [63:0] i_req_wdata;
  logic        o_resp_valid, i_resp_ready, o_resp_err;
  logic [63:0] o_resp_rdata;
  logic [15:0] o_mem_addr;
  logic        o_mem_we;
  logic [7:0]  o_mem_wstrb;
  logic [63:0] o_mem_wdata, i_mem_rdata;

  typedef struct {logic [63:0] rdata; logic err; int acc; int lat;} resp_t;
  typedef struct {logic [15:0] addr; logic [7:0] strb; logic [63:0] data;} wr_t;

  resp_t exp_q[$];
  wr_t   wq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  bit    mem_clr;
  logic [63:0] mem [0:8191];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  sram_access_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_write (i_req_write),
    .i_req_addr  (i_req_addr),
    .i_req_size  (i_req_size),
    .i_req_wdata (i_req_wdata),
    .o_resp_valid(o_resp_valid),
    .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata),
    .o_resp_err  (o_resp_err),
    .o_mem_addr  (o_mem_addr),
    .o_mem_we    (o_mem_we),
    .o_mem_wstrb (o_mem_wstrb),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  // byte-strobed SRAM, read data one cycle after the address
  always @(posedge i_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8192; i++) mem[i] <= '0;
    end else if (o_mem_we) begin
      for (int b = 0; b < 8; b++)
        if (o_mem_wstrb[b]) mem[o_mem_addr[15:3]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
    i_mem_rdata <= mem[o_mem_addr[15:3]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] s, input logic [63:0] d);
    wr_t w;
    w.addr = a; w.strb = s; w.data = d;
    wq.push_back(w);
  endtask

  task automatic drive(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                       input logic [63:0] wdata, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    @(negedge i_clk);
    while (!o_req_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_ready_timeout: got %0b, expected 1", o_req_ready);
      return;
    end
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = addr;
    i_req_size  = size;
    i_req_wdata = wdata;
    ok = 1'b1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                       input logic [63:0] wdata, input logic [63:0] exp_rd, input logic exp_err,
                       input int lat, input int stall);
    bit    ok;
    int    n;
    resp_t r;
    drive(wr, addr, size, wdata, ok);
    if (!ok) return;
    i_resp_ready = (stall == 0);
    r.rdata = exp_rd; r.err = exp_err; r.acc = cyc; r.lat = lat;
    exp_q.push_back(r);
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    if (stall > 0) begin
      n = 0;
      while (!o_resp_valid && n < 20) begin
        @(negedge i_clk);
        n++;
      end
      check("stall_resp_valid", 64'(o_resp_valid), 64'd1);
      repeat (stall) begin
        @(negedge i_clk);
        check("stall_valid_held", 64'(o_resp_valid), 64'd1);
        check("stall_rdata_held", o_resp_rdata, exp_rd);
        check("stall_err_held", 64'(o_resp_err), 64'(exp_err));
        check("stall_req_ready", 64'(o_req_ready), 64'd0);
      end
      i_resp_ready = 1'b1;
    end
  endtask

  initial begin : monitor
    logic  prev_v;
    resp_t e;
    wr_t   w;
    prev_v = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        prev_v = 1'b0;
      end else begin
        if (o_resp_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_unexpected: got rdata 0x%0h err %0b, expected no response", o_resp_rdata, o_resp_err);
          end else begin
            e = exp_q.pop_front();
            check("resp_rdata", o_resp_rdata, e.rdata);
            check("resp_err", 64'(o_resp_err), 64'(e.err));
            check("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
          end
        end
        prev_v = o_resp_valid;
        if (o_mem_we === 1'b1) begin
          if (wq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mem_we_unexpected: got write addr 0x%0h strb 0x%0h, expected no write", o_mem_addr, o_mem_wstrb);
          end else begin
            w = wq.pop_front();
            check("mem_addr", 64'(o_mem_addr), 64'(w.addr));
            check("mem_wstrb", 64'(o_mem_wstrb), 64'(w.strb));
            check("mem_wdata", o_mem_wdata, w.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit ok;
    i_rst = 1'b1; mem_clr = 1'b1;
    i_req_valid = 1'b0; i_req_write = 1'b0; i_req_addr = '0; i_req_size = '0; i_req_wdata = '0;
    i_resp_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rst_req_ready", 64'(o_req_ready), 64'd1);
    check("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    check("rst_resp_err", 64'(o_resp_err), 64'd0);
    check("rst_resp_rdata", o_resp_rdata, 64'd0);
    check("rst_mem_we", 64'(o_mem_we), 64'd0);
    check("rst_mem_wstrb", 64'(o_mem_wstrb), 64'd0);
    check("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    check("rst_mem_wdata", o_mem_wdata, 64'd0);
    mem_clr = 1'b0;
    i_rst   = 1'b0;

    push_wr(16'h0010, 8'hFF, 64'h1122334455667788);
    issue(1'b1, 16'h0010, 3'd3, 64'h1122334455667788, 64'd0, 1'b0, 2, 0);
    issue(1'b0, 16'h0010, 3'd3, 64'd0, 64'h1122334455667788, 1'b0, 3, 0);
    issue(1'b0, 16'h0012, 3'd1, 64'd0, 64'h5566, 1'b0, 3, 0);
    push_wr(16'h0010, 8'h08, 64'hA5000000);
    issue(1'b1, 16'h0013, 3'd0, 64'hA5, 64'd0, 1'b0, 2, 0);
    issue(1'b0, 16'h0010, 3'd3, 64'd0, 64'h11223344A5667788, 1'b0, 3, 0);
`ifdef SRAM_ACCESS_CTRL_SPLIT_EN
    push_wr(16'h0008, 8'hC0, 64'hCCDD000000000000);
    push_wr(16'h0010, 8'h03, 64'h000000000000AABB);
    issue(1'b1, 16'h000E, 3'd2, 64'hAABBCCDD, 64'd0, 1'b0, 3, 0);
    issue(1'b0, 16'h000E, 3'd2, 64'd0, 64'hAABBCCDD, 1'b0, 4, 0);
    issue(1'b0, 16'h000F, 3'd0, 64'd0, 64'hCC, 1'b0, 3, 0);
    push_wr(16'hFFF8, 8'hC0, 64'h3344000000000000);
    push_wr(16'h0000, 8'h03, 64'h0000000000001122);
    issue(1'b1, 16'hFFFE, 3'd2, 64'h11223344, 64'd0, 1'b0, 3, 0);
`else
    issue(1'b1, 16'h000E, 3'd2, 64'hAABBCCDD, 64'd0, 1'b1, 1, 0);
    issue(1'b0, 16'h000E, 3'd2, 64'd0, 64'd0, 1'b1, 1, 0);
    issue(1'b0, 16'h000F, 3'd0, 64'd0, 64'h00, 1'b0, 3, 0);
    issue(1'b1, 16'hFFFE, 3'd2, 64'h11223344, 64'd0, 1'b1, 1, 0);
`endif
    issue(1'b0, 16'h0014, 3'd2, 64'd0, 64'h11223344, 1'b0, 3, 0);
    issue(1'b0, 16'h0020, 3'd4, 64'd0, 64'd0, 1'b1, 1, 5);

    // abort an in-flight write with an asynchronous reset while o_mem_we is high
`ifdef SRAM_ACCESS_CTRL_SPLIT_EN
    push_wr(16'h0028, 8'hC0, 64'h7788000000000000);
    drive(1'b1, 16'h002E, 3'd2, 64'h55667788, ok);
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    @(posedge i_clk);
`else
    drive(1'b1, 16'h0028, 3'd3, 64'h0123456789ABCDEF, ok);
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
`endif
    #1 check("pre_reset_mem_we", 64'(o_mem_we), 64'd1);
    i_rst = 1'b1;
    #1;
    check("abort_mem_we", 64'(o_mem_we), 64'd0);
    check("abort_mem_wstrb", 64'(o_mem_wstrb), 64'd0);
    check("abort_resp_valid", 64'(o_resp_valid), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("post_reset_req_ready", 64'(o_req_ready), 64'd1);
    check("post_reset_resp_valid", 64'(o_resp_valid), 64'd0);
`ifdef SRAM_ACCESS_CTRL_SPLIT_EN
    issue(1'b0, 16'h0010, 3'd3, 64'd0, 64'h11223344A566AABB, 1'b0, 3, 0);
`else
    issue(1'b0, 16'h0010, 3'd3, 64'd0, 64'h11223344A5667788, 1'b0, 3, 0);
`endif

    repeat (6) @(negedge i_clk);
    check("resp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("write_queue_drained", 64'(wq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
